// File: rtl/mux_arb_pkg.sv
// Shared defaults and mode encodings for the N:1 registered data multiplexer.
package mux_arb_pkg;

  localparam int WIDTH_DEF    = 2;
  localparam int CHANNELS_DEF = 4;
  localparam int SEL_W_DEF    = 2;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/rr_pick_nx1.sv
// Rotating priority encoder. It returns the first requesting channel found
// when searching ptr+1, ptr+2, ... (wrapping modulo CHANNELS), with ptr last.
module rr_pick_nx1
  import mux_arb_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                found,
  output logic [SEL_W-1:0]    index
);

  int idx;

  // Walk the search order backwards so the closest requester after ptr wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    index = '0;
    idx   = 0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (req[idx]) begin
        found = 1'b1;
        index = SEL_W'(idx);
      end
    end
  end

endmodule : rr_pick_nx1

// File: rtl/mux_rr_arb_nx1.sv
// N:1 registered data multiplexer. The channel is chosen either by an external
// selector or by a round-robin arbiter. A one-entry output register with a
// ready handshake drives the consumer.
module mux_rr_arb_nx1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input  logic                      clok,
  input  logic                      reset_L,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      ready_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic [CHANNELS-1:0]       grant
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_index;
  logic             rr_found;
  logic [SEL_W-1:0] cand;
  logic             fix_ok;
  logic             eligible;
  logic             load;
  logic [WIDTH-1:0] cand_data;

  rr_pick_nx1 #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .req   (valid_in),
    .ptr   (ptr),
    .found (rr_found),
    .index (rr_index)
  );

  // Candidate selection, load enable and the one-hot grant to the producers.
  always_comb begin
    load      = !valid_out || ready_in;
    fix_ok    = 1'b0;
    cand_data = '0;
    grant     = '0;
    if (int'(selector) < CHANNELS) begin
      fix_ok = valid_in[selector];
    end
    if (mode == MODE_RR) begin
      cand     = rr_index;
      eligible = rr_found;
    end else begin
      cand     = selector;
      eligible = fix_ok;
    end
    if (eligible) begin
      cand_data = data_in[int'(cand)*WIDTH +: WIDTH];
    end
    if (reset_L && load && eligible) begin
      grant[cand] = 1'b1;
    end
  end

  // Output register and round-robin pointer. A bubble is refilled even under backpressure.
  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      chan_out  <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (eligible) begin
        data_out  <= cand_data;
        chan_out  <= cand;
        valid_out <= 1'b1;
        if (mode == MODE_RR) begin
          ptr <= cand;
        end
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule : mux_rr_arb_nx1

// File: tb/tb_mux_rr_arb_nx1.sv
// Directed bench for mux_rr_arb_nx1: reset, fixed select, round-robin order,
// backpressure, bubble fill, and an out-of-range selector on a 3-channel copy.
module tb_mux_rr_arb_nx1;

  logic       clok = 1'b0;
  logic       reset_L;

  logic       mode;
  logic [1:0] selector;
  logic [3:0] valid_in;
  logic [7:0] data_in;
  logic       ready_in;
  logic [1:0] data_out;
  logic       valid_out;
  logic [1:0] chan_out;
  logic [3:0] grant;

  logic       mode3;
  logic [1:0] selector3;
  logic [2:0] valid_in3;
  logic [5:0] data_in3;
  logic       ready_in3;
  logic [1:0] data_out3;
  logic       valid_out3;
  logic [1:0] chan_out3;
  logic [2:0] grant3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clok = ~clok;

  mux_rr_arb_nx1 #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) u_dut (
    .clok      (clok),
    .reset_L   (reset_L),
    .mode      (mode),
    .selector  (selector),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .chan_out  (chan_out),
    .grant     (grant)
  );

  mux_rr_arb_nx1 #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .clok      (clok),
    .reset_L   (reset_L),
    .mode      (mode3),
    .selector  (selector3),
    .valid_in  (valid_in3),
    .data_in   (data_in3),
    .ready_in  (ready_in3),
    .data_out  (data_out3),
    .valid_out (valid_out3),
    .chan_out  (chan_out3),
    .grant     (grant3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past one rising edge; registered outputs are sampled 1ns later.
  task automatic step();
    @(posedge clok);
    #1;
  endtask

  initial begin
    // Reset held with all channels valid.
    reset_L   = 1'b0;
    mode      = 1'b0;
    selector  = 2'd0;
    valid_in  = 4'b1111;
    data_in   = 8'hE4;          // ch0=0, ch1=1, ch2=2, ch3=3
    ready_in  = 1'b1;
    mode3     = 1'b0;
    selector3 = 2'd3;
    valid_in3 = 3'b111;
    data_in3  = 6'b10_01_00;
    ready_in3 = 1'b1;
    repeat (3) step();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data",  32'(data_out),  32'd0);
    check("rst_chan",  32'(chan_out),  32'd0);
    check("rst_grant", 32'(grant),     32'd0);

    // Fixed mode, channel 2.
    reset_L  = 1'b1;
    selector = 2'd2;
    valid_in = 4'b0100;
    data_in  = 8'h30;           // ch2=2'b11
    #1;
    check("fix_grant", 32'(grant), 32'b0100);
    step();
    check("fix_data",  32'(data_out),  32'h3);
    check("fix_chan",  32'(chan_out),  32'd2);
    check("fix_valid", 32'(valid_out), 32'd1);
    valid_in = 4'b0000;
    #1;
    check("fix_nogrant", 32'(grant), 32'd0);
    step();
    check("fix_drop_valid", 32'(valid_out), 32'd0);
    check("fix_hold_data",  32'(data_out),  32'h3);
    check("fix_hold_chan",  32'(chan_out),  32'd2);

    // Asynchronous reset mid-cycle while holding a valid word.
    valid_in = 4'b0100;
    step();
    check("pre_async_valid", 32'(valid_out), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    check("async_valid", 32'(valid_out), 32'd0);
    check("async_data",  32'(data_out),  32'd0);
    check("async_chan",  32'(chan_out),  32'd0);
    check("async_grant", 32'(grant),     32'd0);

    // Round-robin with all channels valid: pointer starts at 3, so 0 is first.
    mode     = 1'b1;
    valid_in = 4'b1111;
    data_in  = 8'hE4;
    step();
    reset_L = 1'b1;
    #1;
    check("rr_first_grant", 32'(grant), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("rr_all_chan%0d", i), 32'(chan_out), 32'(i % 4));
      check($sformatf("rr_all_data%0d", i), 32'(data_out), 32'(i % 4));
    end

    // Only channels 1 and 3 valid: 1,3,1,3 then 1 again.
    valid_in = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_odd_chan%0d", i), 32'(chan_out), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    check("bp_start_data", 32'(data_out), 32'h1);

    // Backpressure: everything holds and no grant while inputs churn.
    ready_in = 1'b0;
    valid_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      data_in = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h5A;
      #1;
      check($sformatf("bp_grant%0d", i), 32'(grant), 32'd0);
      step();
      check($sformatf("bp_data%0d", i),  32'(data_out),  32'h1);
      check($sformatf("bp_chan%0d", i),  32'(chan_out),  32'd1);
      check($sformatf("bp_valid%0d", i), 32'(valid_out), 32'd1);
    end
    // Release: pointer stayed at 1, so channel 2 goes next.
    ready_in = 1'b1;
    data_in  = 8'hE4;
    #1;
    check("bp_release_grant", 32'(grant), 32'b0100);
    step();
    check("bp_release_chan", 32'(chan_out), 32'd2);
    check("bp_release_data", 32'(data_out), 32'h2);

    // Bubble fill: empty register loads even with ready_in low.
    valid_in = 4'b0000;
    step();
    check("bubble_empty", 32'(valid_out), 32'd0);
    ready_in = 1'b0;
    valid_in = 4'b0010;
    #1;
    check("bubble_grant", 32'(grant), 32'b0010);
    step();
    check("bubble_valid", 32'(valid_out), 32'd1);
    check("bubble_chan",  32'(chan_out),  32'd1);
    check("bubble_data",  32'(data_out),  32'h1);

    // Out-of-range selector on the 3-channel instance (selector=3 since reset).
    check("oor_grant", 32'(grant3),     32'd0);
    check("oor_valid", 32'(valid_out3), 32'd0);
    selector3 = 2'd2;
    #1;
    check("c3_grant", 32'(grant3), 32'b100);
    step();
    check("c3_valid", 32'(valid_out3), 32'd1);
    check("c3_chan",  32'(chan_out3),  32'd2);
    check("c3_data",  32'(data_out3),  32'h2);
    selector3 = 2'd3;
    #1;
    check("oor2_grant", 32'(grant3), 32'd0);
    step();
    check("oor2_valid", 32'(valid_out3), 32'd0);
    check("oor2_hold",  32'(data_out3),  32'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mux_rr_arb_nx1

// File: doc/mux_rr_arb_nx1.md
Name: mux_rr_arb_nx1

Overview:
- Parametrised N-to-1 registered data multiplexer with per-channel valid and a downstream ready handshake.
- Two selection modes:
  - Fixed: an external selector picks the channel.
  - Round-robin: an internal arbiter rotates among valid channels.
- Sits between parallel lane producers and a single-lane consumer. It is the next-generation replacement for the 2-bit 2:1 valid-gated mux in the data path.

Parameters:
- WIDTH, 2, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, selector and channel-id width; must satisfy 2**SEL_W >= CHANNELS

Ports:
- clok  input  1  single clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- selector  input  SEL_W  channel index used when mode=0
- valid_in  input  CHANNELS  per-channel valid; bit i qualifies channel i
- data_in  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- ready_in  input  1  downstream able to accept data_out this cycle
- data_out  output  WIDTH  registered selected data
- valid_out  output  1  registered; data_out holds a valid word
- chan_out  output  SEL_W  registered index of the channel that produced data_out
- grant  output  CHANNELS  combinational one-hot; channel consumed this cycle (producer may advance)

Behaviour:
- Reset:
  - reset_L=0 immediately (asynchronously) forces data_out=0, valid_out=0, chan_out=0, rr pointer=CHANNELS-1.
  - grant=0 while in reset.
  - Deassertion takes effect at the next rising clok.
  - Reset mid-transfer drops the held word; no recovery.
- Load enable: load = !valid_out | ready_in. This is a one-entry pipeline register; a bubble never blocks.
- Candidate pick (combinational):
  - mode=0: candidate = selector, eligible only if selector < CHANNELS and valid_in[selector]=1.
  - mode=1: first i with valid_in[i]=1, searching (ptr+1), (ptr+2) ... with wrap modulo CHANNELS. The search includes ptr itself last.
- grant[cand]=1 only when load=1 and a candidate is eligible; otherwise grant=0.
- On rising clok with load=1:
  - Eligible candidate: data_out<=data_in[cand], chan_out<=cand, valid_out<=1.
  - In mode=1 only, additionally ptr<=cand.
  - No eligible candidate: valid_out<=0, while data_out and chan_out hold their last values.
- On rising clok with load=0 (valid_out=1, ready_in=0): all registers hold, ptr holds, grant=0.
- Latency: one cycle from grant to valid_out.
- Throughput: one word per cycle while ready_in=1.
- Fairness (mode=1): with all channels valid continuously and ready_in=1, grants follow 0,1,2,...,CHANNELS-1,0,... Starvation is bounded by CHANNELS-1 grants.
- Mode switch: takes effect at the next load. ptr is kept across mode=0 periods (not updated in fixed mode).
- Selector >= CHANNELS in mode=0: no grant, valid_out<=0 on load.
- Simultaneous ready_in=1 and new candidate: the old word is accepted and the new word is loaded in the same edge.
- Changes on valid_in or data_in while stalled have no effect on the outputs.

Decomposition:
- Shared package mux_arb_pkg:
  - Defaults WIDTH_DEF=2, CHANNELS_DEF=4, SEL_W_DEF=2.
  - Mode constants MODE_FIXED=0, MODE_RR=1.
- One sub-module rr_pick_nx1:
  - Parameters CHANNELS, SEL_W.
  - Inputs: req vector, pointer.
  - Outputs: found, index.
  - Purely combinational rotating priority encoder.
- Top level holds the output register, ptr and load logic.

Test Plan:
- Reset: hold reset_L=0 with valid_in=4'b1111 and clok toggling -> valid_out=0, data_out=0, chan_out=0, grant=0. Assert reset_L=0 asynchronously mid-cycle while valid_out=1 -> outputs clear before the next edge.
- Fixed mode: mode=0, selector=2, valid_in=4'b0100, data_in ch2=2'b11, ready_in=1 -> grant=4'b0100; next cycle data_out=2'b11, chan_out=2, valid_out=1. Then valid_in[2]=0 -> valid_out=0, data_out stays 2'b11.
- Round-robin fairness: mode=1, valid_in=4'b1111, ready_in=1 for 8 cycles -> chan_out sequence 0,1,2,3,0,1,2,3. Then valid_in=4'b1010 -> chan_out sequence 1,3,1,3.
- Backpressure: valid_out=1 with data_out=2'b01; ready_in=0 for 3 cycles while data_in changes -> data_out, chan_out and ptr hold and grant=0. Then ready_in=1 -> the next channel in rr order loads in that edge.
- Bubble fill: valid_out=0, ready_in=0, valid_in[1]=1 -> grant=4'b0010 and valid_out=1 next cycle despite ready_in=0.
- Out-of-range selector: CHANNELS=3, SEL_W=2, mode=0, selector=3, valid_in=3'b111 -> grant=0 and valid_out=0.
